// File: rtl/dmem_responder_pkg.sv
// Shared types and limits for the data-memory responder.
// Build option: DMEM_MISALIGN_ERR_EN adds the misaligned byte-enable check.
package dmem_responder_pkg;

    localparam int DMEM_WAIT_MAX = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef enum logic {
        LS_LOAD  = 1'b0,
        LS_STORE = 1'b1
    } ls_op_t;

    typedef struct packed {
        ls_op_t      op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    // Legal shapes are byte, aligned half-word and aligned word; be == 0 is never flagged.
    function automatic logic dmem_misaligned(input logic [1:0] a, input logic [3:0] be);
        logic legal;
        legal = (be == (4'b0001 << a)) ||
                (!a[0] && (be == (4'b0011 << a))) ||
                ((a == 2'd0) && (be == 4'b1111));
        return (be != 4'b0000) && !legal;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store unit to data-memory request/response bus.
interface dmem_responder_if;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic [3:0]  d_be;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    modport master (
        output d_req, d_we, d_addr, d_wr_data, d_be,
        input  d_gnt, d_rvalid, d_rdata, d_err
    );

    modport slave (
        input  d_req, d_we, d_addr, d_wr_data, d_be,
        output d_gnt, d_rvalid, d_rdata, d_err
    );
endinterface

// File: rtl/dmem_responder_sram.sv
// Single-port byte-write storage with synchronous read; contents are never reset.
module dmem_sram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_we && i_be[g]) begin
                r_mem[i_addr] <= i_wdata[8*g +: 8];
            end
            if (i_re) begin
                r_q <= r_mem[i_addr];
            end
        end

        assign o_rdata[8*g +: 8] = r_q;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, fixed wait states, one-cycle response strobe.
// Build option: DMEM_MISALIGN_ERR_EN rejects misaligned byte enables with d_err.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   d_if
);

    localparam int         AW    = $clog2(DEPTH_WORDS);
    localparam int         WS    = (WAIT_STATES > DMEM_WAIT_MAX) ? DMEM_WAIT_MAX : WAIT_STATES;
    localparam logic [2:0] WS_LD = 3'(WS);

    dmem_state_t r_state;
    logic [2:0]  r_cnt;
    dmem_req_t   r_req;
    logic        r_gnt;
    logic        r_rvalid;
    logic        r_err;
    logic        r_ld_ok;

    dmem_req_t   w_src;
    logic        w_accept;
    logic        w_oor;
    logic        w_mis;
    logic        w_src_err;
    logic        w_rd_en;
    logic        w_wr_en;
    logic [31:0] w_sram_q;

    assign w_accept = d_if.d_req && r_gnt;

    // In IDLE the live bus is the source so a zero-wait access can read and judge on the accept edge.
    always_comb begin
        w_src = r_req;
        if (r_state == IDLE) begin
            w_src.op    = ls_op_t'(d_if.d_we);
            w_src.addr  = d_if.d_addr;
            w_src.wdata = d_if.d_wr_data;
            w_src.be    = d_if.d_be;
        end
    end

    assign w_oor = w_src.addr[31:2] >= 30'(DEPTH_WORDS);

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_mis = dmem_misaligned(w_src.addr[1:0], w_src.be);
`else
    logic w_unused_lo;
    assign w_mis       = 1'b0;
    assign w_unused_lo = ^w_src.addr[1:0];
`endif

    assign w_src_err = w_oor || w_mis;
    assign w_rd_en   = ((r_state == IDLE) && w_accept && (WS == 0)) ||
                       ((r_state == WAIT) && (r_cnt == 3'd1));
    assign w_wr_en   = (r_state == RESP) && (r_req.op == LS_STORE) && !r_err;

    dmem_sram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_be    (r_req.be),
        .i_re    (w_rd_en),
        .i_addr  (w_src.addr[AW+1:2]),
        .i_wdata (r_req.wdata),
        .o_rdata (w_sram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= 3'd0;
            r_req    <= '0;
            r_gnt    <= 1'b1;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_ld_ok  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req <= w_src;
                        r_gnt <= 1'b0;
                        if (WS == 0) begin
                            r_state  <= RESP;
                            r_rvalid <= 1'b1;
                            r_err    <= w_src_err;
                            r_ld_ok  <= (w_src.op == LS_LOAD) && !w_src_err;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= WS_LD;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == 3'd1) begin
                        r_state  <= RESP;
                        r_cnt    <= 3'd0;
                        r_rvalid <= 1'b1;
                        r_err    <= w_src_err;
                        r_ld_ok  <= (w_src.op == LS_LOAD) && !w_src_err;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                RESP: begin
                    r_state  <= IDLE;
                    r_gnt    <= 1'b1;
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                    r_ld_ok  <= 1'b0;
                end
                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= 3'd0;
                    r_gnt    <= 1'b1;
                    r_rvalid <= 1'b0;
                    r_err    <= 1'b0;
                    r_ld_ok  <= 1'b0;
                end
            endcase
        end
    end

    assign d_if.d_gnt    = r_gnt;
    assign d_if.d_rvalid = r_rvalid;
    assign d_if.d_err    = r_err;
    assign d_if.d_rdata  = (r_rvalid && r_ld_ok) ? w_sram_q : 32'h0;

endmodule
